fft8_fwd_serial: RTL and testbench

Forward 8-point radix-2 DIF FFT core, the analysis-side counterpart of the team's parallel IFFT stage. Accepts one complex Q1.15 sample per handshake, stores a frame of 8, computes it in place with a single shared butterfly over 12 cycles, then streams the 8 bins out in natural order. It sits between the sample source and the spectral-processing / IFFT chain.

---
 rtl/fft8_pkg.sv | 23 ++
 rtl/fft8_bfly.sv | 80 ++++++++
 rtl/fft8_fwd_serial.sv | 229 ++++++++++++++++++++++
 tb/tb_fft8_fwd_serial.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/fft8_pkg.sv
// Shared constants, FSM encoding and index helper for the serial 8-point forward FFT.
// Optional stage scaling is selected with FFT8_STAGE_SCALE_EN (see fft8_bfly).
package fft8_pkg;

    // Forward twiddles e^(-j*2*pi*t/8) in Q1.15; W^0 and W^2 need no multiplier
    localparam logic signed [15:0] W1_RE = 16'sh5A82;
    localparam logic signed [15:0] W1_IM = -16'sh5A82;
    localparam logic signed [15:0] W3_RE = -16'sh5A82;
    localparam logic signed [15:0] W3_IM = -16'sh5A82;

    localparam logic signed [33:0] ROUND_CONST = 34'sd16384;

    typedef enum logic [1:0] {
        LOAD   = 2'd0,
        COMP   = 2'd1,
        UNLOAD = 2'd2
    } fft_state_t;

    function automatic logic [2:0] bitrev3(input logic [2:0] k);
        return {k[0], k[1], k[2]};
    endfunction

endpackage

// File: rtl/fft8_bfly.sv
// Combinational radix-2 DIF butterfly: a' = a + b, b' = (a - b) * W^tw.
// With FFT8_STAGE_SCALE_EN defined both outputs are halved (rounded) before the twiddle.
module fft8_bfly
    import fft8_pkg::*;
(
    input  logic [15:0] a_re,
    input  logic [15:0] a_im,
    input  logic [15:0] b_re,
    input  logic [15:0] b_im,
    input  logic [1:0]  tw,
    output logic [15:0] ya_re,
    output logic [15:0] ya_im,
    output logic [15:0] yb_re,
    output logic [15:0] yb_im
);

    logic signed [16:0] sum_re;
    logic signed [16:0] sum_im;
    logic signed [16:0] diff_re;
    logic signed [16:0] diff_im;
    logic signed [16:0] s_re;
    logic signed [16:0] s_im;
    logic signed [16:0] d_re;
    logic signed [16:0] d_im;
    logic signed [15:0] w_re;
    logic signed [15:0] w_im;
    logic signed [32:0] p_rr;
    logic signed [32:0] p_ii;
    logic signed [32:0] p_ri;
    logic signed [32:0] p_ir;
    logic signed [33:0] acc_re;
    logic signed [33:0] acc_im;

    always_comb begin
        sum_re  = 17'($signed(a_re)) + 17'($signed(b_re));
        sum_im  = 17'($signed(a_im)) + 17'($signed(b_im));
        diff_re = 17'($signed(a_re)) - 17'($signed(b_re));
        diff_im = 17'($signed(a_im)) - 17'($signed(b_im));
`ifdef FFT8_STAGE_SCALE_EN
        s_re = (sum_re + 17'sd1) >>> 1;
        s_im = (sum_im + 17'sd1) >>> 1;
        d_re = (diff_re + 17'sd1) >>> 1;
        d_im = (diff_im + 17'sd1) >>> 1;
`else
        s_re = sum_re;
        s_im = sum_im;
        d_re = diff_re;
        d_im = diff_im;
`endif
        // Only W^1 and W^3 reach the multiplier; tw[1] picks between them
        w_re = tw[1] ? W3_RE : W1_RE;
        w_im = tw[1] ? W3_IM : W1_IM;

        p_rr   = 33'(d_re) * 33'(w_re);
        p_ii   = 33'(d_im) * 33'(w_im);
        p_ri   = 33'(d_re) * 33'(w_im);
        p_ir   = 33'(d_im) * 33'(w_re);
        acc_re = 34'(p_rr) - 34'(p_ii);
        acc_im = 34'(p_ri) + 34'(p_ir);

        ya_re = 16'(s_re);
        ya_im = 16'(s_im);

        case (tw)
            2'd0: begin
                yb_re = 16'(d_re);
                yb_im = 16'(d_im);
            end
            2'd2: begin
                yb_re = 16'(d_im);
                yb_im = 16'(-d_re);
            end
            default: begin
                yb_re = 16'((acc_re + ROUND_CONST) >>> 15);
                yb_im = 16'((acc_im + ROUND_CONST) >>> 15);
            end
        endcase
    end

endmodule

// File: rtl/fft8_fwd_serial.sv
// Serial 8-point forward DIF FFT: load 8 samples, 12 in-place butterflies, unload bins in natural order.
// Build option FFT8_STAGE_SCALE_EN enables per-stage 1/2 scaling inside fft8_bfly.
module fft8_fwd_serial
    import fft8_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    input  logic [15:0] in_re,
    input  logic [15:0] in_im,
    output logic        in_ready,
    output logic        out_valid,
    output logic [15:0] out_re,
    output logic [15:0] out_im,
    output logic [2:0]  out_idx,
    output logic        out_last,
    input  logic        out_ready,
    output logic        frame_done
);

    fft_state_t state_q;
    fft_state_t state_d;

    logic [2:0]  load_cnt_q;
    logic [2:0]  load_cnt_d;
    logic [3:0]  bfly_cnt_q;
    logic [3:0]  bfly_cnt_d;
    logic [15:0] mem_re_q [8];
    logic [15:0] mem_re_d [8];
    logic [15:0] mem_im_q [8];
    logic [15:0] mem_im_d [8];

    logic        in_ready_q;
    logic        in_ready_d;
    logic        out_valid_q;
    logic        out_valid_d;
    logic [15:0] out_re_q;
    logic [15:0] out_re_d;
    logic [15:0] out_im_q;
    logic [15:0] out_im_d;
    logic [2:0]  out_idx_q;
    logic [2:0]  out_idx_d;
    logic        out_last_q;
    logic        out_last_d;
    logic        frame_done_q;
    logic        frame_done_d;

    logic        in_fire;
    logic        out_fire;
    logic [1:0]  stage;
    logic [1:0]  pair;
    logic [2:0]  idx_a;
    logic [2:0]  idx_b;
    logic [1:0]  tw;
    logic [2:0]  next_idx;
    logic [15:0] ya_re;
    logic [15:0] ya_im;
    logic [15:0] yb_re;
    logic [15:0] yb_im;

    assign in_fire  = (state_q == LOAD) && in_valid && in_ready_q;
    assign out_fire = out_valid_q && out_ready;
    assign stage    = bfly_cnt_q[3:2];
    assign pair     = bfly_cnt_q[1:0];
    assign next_idx = out_idx_q + 3'd1;

    // Butterfly operand addresses and twiddle for the current schedule step
    always_comb begin
        idx_a = 3'd0;
        idx_b = 3'd0;
        tw    = 2'd0;
        case (stage)
            2'd0: begin
                idx_a = {1'b0, pair};
                idx_b = {1'b1, pair};
                tw    = pair;
            end
            2'd1: begin
                idx_a = {pair[1], 1'b0, pair[0]};
                idx_b = {pair[1], 1'b1, pair[0]};
                tw    = {pair[0], 1'b0};
            end
            default: begin
                idx_a = {pair, 1'b0};
                idx_b = {pair, 1'b1};
                tw    = 2'd0;
            end
        endcase
    end

    fft8_bfly u_bfly (
        .a_re  (mem_re_q[idx_a]),
        .a_im  (mem_im_q[idx_a]),
        .b_re  (mem_re_q[idx_b]),
        .b_im  (mem_im_q[idx_b]),
        .tw    (tw),
        .ya_re (ya_re),
        .ya_im (ya_im),
        .yb_re (yb_re),
        .yb_im (yb_im)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= LOAD;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            LOAD: begin
                if (in_fire && (load_cnt_q == 3'd7)) begin
                    state_d = COMP;
                end
            end
            COMP: begin
                if (bfly_cnt_q == 4'd11) begin
                    state_d = UNLOAD;
                end
            end
            UNLOAD: begin
                if (out_fire && (out_idx_q == 3'd7)) begin
                    state_d = LOAD;
                end
            end
            default: state_d = LOAD;
        endcase
    end

    always_comb begin
        load_cnt_d   = load_cnt_q;
        bfly_cnt_d   = bfly_cnt_q;
        mem_re_d     = mem_re_q;
        mem_im_d     = mem_im_q;
        out_valid_d  = out_valid_q;
        out_re_d     = out_re_q;
        out_im_d     = out_im_q;
        out_idx_d    = out_idx_q;
        out_last_d   = out_last_q;
        frame_done_d = 1'b0;
        in_ready_d   = (state_d == LOAD);

        case (state_q)
            LOAD: begin
                if (in_fire) begin
                    mem_re_d[load_cnt_q] = in_re;
                    mem_im_d[load_cnt_q] = in_im;
                    load_cnt_d           = load_cnt_q + 3'd1;
                end
            end
            COMP: begin
                mem_re_d[idx_a] = ya_re;
                mem_im_d[idx_a] = ya_im;
                mem_re_d[idx_b] = yb_re;
                mem_im_d[idx_b] = yb_im;
                bfly_cnt_d      = bfly_cnt_q + 4'd1;
                // Bin 0 is registered on the final butterfly edge so it is visible immediately
                if (bfly_cnt_q == 4'd11) begin
                    bfly_cnt_d  = 4'd0;
                    out_valid_d = 1'b1;
                    out_idx_d   = 3'd0;
                    out_last_d  = 1'b0;
                    out_re_d    = mem_re_d[bitrev3(3'd0)];
                    out_im_d    = mem_im_d[bitrev3(3'd0)];
                end
            end
            UNLOAD: begin
                if (out_fire) begin
                    if (out_idx_q == 3'd7) begin
                        out_valid_d  = 1'b0;
                        out_last_d   = 1'b0;
                        out_idx_d    = 3'd0;
                        out_re_d     = 16'd0;
                        out_im_d     = 16'd0;
                        frame_done_d = 1'b1;
                    end else begin
                        out_idx_d  = next_idx;
                        out_last_d = (next_idx == 3'd7);
                        out_re_d   = mem_re_q[bitrev3(next_idx)];
                        out_im_d   = mem_im_q[bitrev3(next_idx)];
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            load_cnt_q   <= 3'd0;
            bfly_cnt_q   <= 4'd0;
            for (int i = 0; i < 8; i++) begin
                mem_re_q[i] <= 16'd0;
                mem_im_q[i] <= 16'd0;
            end
            in_ready_q   <= 1'b0;
            out_valid_q  <= 1'b0;
            out_re_q     <= 16'd0;
            out_im_q     <= 16'd0;
            out_idx_q    <= 3'd0;
            out_last_q   <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            load_cnt_q   <= load_cnt_d;
            bfly_cnt_q   <= bfly_cnt_d;
            mem_re_q     <= mem_re_d;
            mem_im_q     <= mem_im_d;
            in_ready_q   <= in_ready_d;
            out_valid_q  <= out_valid_d;
            out_re_q     <= out_re_d;
            out_im_q     <= out_im_d;
            out_idx_q    <= out_idx_d;
            out_last_q   <= out_last_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign in_ready   = in_ready_q;
    assign out_valid  = out_valid_q;
    assign out_re     = out_re_q;
    assign out_im     = out_im_q;
    assign out_idx    = out_idx_q;
    assign out_last   = out_last_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_fft8_fwd_serial.sv
// Directed self-checking bench for fft8_fwd_serial with hand-computed expected bins.
// Impulse expectation follows FFT8_STAGE_SCALE_EN; all other vectors assume the unscaled build.
module tb_fft8_fwd_serial;

    localparam logic [15:0] Z     = 16'd0;
    localparam logic [15:0] P1000 = 16'd1000;
    localparam logic [15:0] N1000 = 16'hFC18;
    localparam logic [15:0] P707  = 16'd707;
    localparam logic [15:0] N707  = 16'hFD3D;
`ifdef FFT8_STAGE_SCALE_EN
    localparam logic [15:0] IMP_BIN = 16'd125;
`else
    localparam logic [15:0] IMP_BIN = 16'd1000;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic [15:0] in_re = 16'd0;
    logic [15:0] in_im = 16'd0;
    logic        out_ready = 1'b1;
    logic        in_ready;
    logic        out_valid;
    logic [15:0] out_re;
    logic [15:0] out_im;
    logic [2:0]  out_idx;
    logic        out_last;
    logic        frame_done;

    int checks = 0;
    int errors = 0;
    int cycle = 0;
    int done_cycle = 0;
    int first_done = 0;
    int latency = 0;

    logic [15:0] src_re [8];
    logic [15:0] src_im [8];
    logic [15:0] exp_re [8];
    logic [15:0] exp_im [8];

    fft8_fwd_serial dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_re      (in_re),
        .in_im      (in_im),
        .in_ready   (in_ready),
        .out_valid  (out_valid),
        .out_re     (out_re),
        .out_im     (out_im),
        .out_idx    (out_idx),
        .out_last   (out_last),
        .out_ready  (out_ready),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0d (0x%h) expected %0d (0x%h)",
                   tag, $signed(obs), obs, $signed(exp), exp);
        end
    endtask

    task automatic applyStimulus(input bit keep_valid);
        int g;
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1;
            in_re    = src_re[i];
            in_im    = src_im[i];
            g = 0;
            while (!in_ready && g < 64) begin
                tick();
                g++;
            end
            checkOutput($sformatf("load%0d_ready", i), {15'd0, in_ready}, 16'd1);
            tick();
        end
        if (!keep_valid) in_valid = 1'b0;
    endtask

    task automatic collectFrame(input int stall_bin, input int stall_len, input bit check_pulse);
        int g;
        for (int k = 0; k < 8; k++) begin
            g = 0;
            while (!out_valid && g < 64) begin
                tick();
                g++;
            end
            checkOutput($sformatf("bin%0d_valid", k), {15'd0, out_valid}, 16'd1);
            if (k == stall_bin) begin
                out_ready = 1'b0;
                for (int s = 0; s < stall_len; s++) begin
                    tick();
                    checkOutput($sformatf("stall%0d_re", s), out_re, exp_re[k]);
                    checkOutput($sformatf("stall%0d_im", s), out_im, exp_im[k]);
                    checkOutput($sformatf("stall%0d_idx", s), {13'd0, out_idx}, 16'(k));
                    checkOutput($sformatf("stall%0d_in_ready", s), {15'd0, in_ready}, 16'd0);
                    checkOutput($sformatf("stall%0d_valid", s), {15'd0, out_valid}, 16'd1);
                end
                out_ready = 1'b1;
            end
            checkOutput($sformatf("bin%0d_re", k), out_re, exp_re[k]);
            checkOutput($sformatf("bin%0d_im", k), out_im, exp_im[k]);
            checkOutput($sformatf("bin%0d_idx", k), {13'd0, out_idx}, 16'(k));
            checkOutput($sformatf("bin%0d_last", k), {15'd0, out_last}, (k == 7) ? 16'd1 : 16'd0);
            tick();
        end
        checkOutput("done_pulse", {15'd0, frame_done}, 16'd1);
        checkOutput("done_valid_low", {15'd0, out_valid}, 16'd0);
        checkOutput("done_in_ready", {15'd0, in_ready}, 16'd1);
        done_cycle = cycle;
        if (check_pulse) begin
            tick();
            checkOutput("done_single_pulse", {15'd0, frame_done}, 16'd0);
        end
    endtask

    initial begin
        // Reset state
        tick();
        tick();
        checkOutput("rst_in_ready", {15'd0, in_ready}, 16'd0);
        checkOutput("rst_out_valid", {15'd0, out_valid}, 16'd0);
        checkOutput("rst_out_re", out_re, 16'd0);
        checkOutput("rst_frame_done", {15'd0, frame_done}, 16'd0);
        reset = 1'b0;
        checkOutput("rel_in_ready_before_edge", {15'd0, in_ready}, 16'd0);
        tick();
        checkOutput("rel_in_ready_after_edge", {15'd0, in_ready}, 16'd1);

        $display("[TB] test 1: impulse");
        src_re = '{P1000, Z, Z, Z, Z, Z, Z, Z};
        src_im = '{Z, Z, Z, Z, Z, Z, Z, Z};
        exp_re = '{IMP_BIN, IMP_BIN, IMP_BIN, IMP_BIN, IMP_BIN, IMP_BIN, IMP_BIN, IMP_BIN};
        exp_im = '{Z, Z, Z, Z, Z, Z, Z, Z};
        applyStimulus(1'b0);
        checkOutput("comp_in_ready", {15'd0, in_ready}, 16'd0);
        latency = 0;
        while (!out_valid && latency < 64) begin
            tick();
            latency++;
        end
        checkOutput("first_bin_latency", 16'(latency), 16'd12);
        collectFrame(-1, 0, 1'b1);

        $display("[TB] test 2: DC");
        src_re = '{P1000, P1000, P1000, P1000, P1000, P1000, P1000, P1000};
        src_im = '{Z, Z, Z, Z, Z, Z, Z, Z};
        exp_re = '{16'd8000, Z, Z, Z, Z, Z, Z, Z};
        exp_im = '{Z, Z, Z, Z, Z, Z, Z, Z};
        applyStimulus(1'b0);
        collectFrame(-1, 0, 1'b1);

        $display("[TB] test 3: unit at x1");
        src_re = '{Z, P1000, Z, Z, Z, Z, Z, Z};
        src_im = '{Z, Z, Z, Z, Z, Z, Z, Z};
        exp_re = '{P1000, P707, Z, N707, N1000, N707, Z, P707};
        exp_im = '{Z, N707, N1000, N707, Z, P707, P1000, P707};
        applyStimulus(1'b0);
        collectFrame(-1, 0, 1'b1);

        $display("[TB] test 4: backpressure on bin 3");
        applyStimulus(1'b0);
        collectFrame(3, 5, 1'b1);

        $display("[TB] test 5: reset during compute");
        applyStimulus(1'b0);
        repeat (6) tick();
        reset = 1'b1;
        #1;
        checkOutput("midrst_in_ready", {15'd0, in_ready}, 16'd0);
        checkOutput("midrst_out_valid", {15'd0, out_valid}, 16'd0);
        checkOutput("midrst_out_re", out_re, 16'd0);
        checkOutput("midrst_out_im", out_im, 16'd0);
        checkOutput("midrst_out_idx", {13'd0, out_idx}, 16'd0);
        checkOutput("midrst_out_last", {15'd0, out_last}, 16'd0);
        checkOutput("midrst_frame_done", {15'd0, frame_done}, 16'd0);
        tick();
        tick();
        reset = 1'b0;
        checkOutput("midrst_rel_before_edge", {15'd0, in_ready}, 16'd0);
        tick();
        checkOutput("midrst_rel_after_edge", {15'd0, in_ready}, 16'd1);
        src_re = '{P1000, Z, Z, Z, Z, Z, Z, Z};
        exp_re = '{IMP_BIN, IMP_BIN, IMP_BIN, IMP_BIN, IMP_BIN, IMP_BIN, IMP_BIN, IMP_BIN};
        exp_im = '{Z, Z, Z, Z, Z, Z, Z, Z};
        applyStimulus(1'b0);
        collectFrame(-1, 0, 1'b1);

        $display("[TB] test 6: back-to-back frames");
        applyStimulus(1'b1);
        collectFrame(-1, 0, 1'b0);
        first_done = done_cycle;
        src_re = '{Z, P1000, Z, Z, Z, Z, Z, Z};
        exp_re = '{P1000, P707, Z, N707, N1000, N707, Z, P707};
        exp_im = '{Z, N707, N1000, N707, Z, P707, P1000, P707};
        applyStimulus(1'b1);
        collectFrame(-1, 0, 1'b0);
        checkOutput("frame_period", 16'(done_cycle - first_done), 16'd28);
        in_valid = 1'b0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
